// File: rtl/mipi_rx_byte_align_if.sv
// Lane interface for the MIPI D-PHY HS byte aligner.
// Carries the raw deserialised stream into the aligner, the aligned byte
// stream and lane status out of it, and a debug copy of the FSM state.
//   hs_en       lane in HS mode; low ends the burst
//   raw_byte    unaligned deserialised bits, bit0 = earliest received
//   raw_valid   raw_byte valid this cycle
//   byte_out    aligned byte, bit0 = earliest received
//   byte_valid  byte_out valid, single cycle per byte
//   sof         marks the first aligned byte after sync lock
//   aligned     high while locked
//   bit_offset  locked bit offset, holds its last value outside lock
//   sync_err    one-cycle pulse on hunt timeout
//   dbg_state   current FSM state (0 IDLE, 1 HUNT, 2 ALIGNED, 3 ERROR)
// Handshake: a raw beat is consumed on every rising clock edge where
// raw_valid is high and hs_en is high; there is no back-pressure. Each
// consumed beat in ALIGNED yields exactly one byte_valid cycle on the next
// clock, and byte_out is only meaningful while byte_valid is high.
interface mipi_rx_byte_align_if;
  logic       hs_en;
  logic [7:0] raw_byte;
  logic       raw_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sof;
  logic       aligned;
  logic [2:0] bit_offset;
  logic       sync_err;
  logic [1:0] dbg_state;

  // Deserialiser / stimulus side
  modport master (
    output hs_en, raw_byte, raw_valid,
    input  byte_out, byte_valid, sof, aligned, bit_offset, sync_err, dbg_state
  );

  // Aligner side
  modport slave (
    input  hs_en, raw_byte, raw_valid,
    output byte_out, byte_valid, sof, aligned, bit_offset, sync_err, dbg_state
  );
endinterface

// File: rtl/mipi_rx_byte_align.sv
// Per-lane MIPI D-PHY HS byte aligner.
// Hunts for the HS sync byte in the raw 1:8 deserialised stream, locks the
// bit offset, then forwards byte-aligned payload with a start-of-frame
// marker. A hunt that sees no sync within HUNT_TIMEOUT valid beats raises a
// one-cycle sync_err and parks in ERROR until hs_en drops.
// Ports:
//   clk      byte clock from the deserialiser
//   rst_n    asynchronous active-low reset
//   lane_if  slave modport of mipi_rx_byte_align_if (stream in, bytes out)
module mipi_rx_byte_align #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mipi_rx_byte_align_if.slave   lane_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_ALIGNED = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(HUNT_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] hunt_cnt_q, hunt_cnt_d;
  logic [2:0] bit_offset_q, bit_offset_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic       sof_q, sof_d;
  logic       sof_pend_q, sof_pend_d;
  logic       sync_err_q, sync_err_d;

  logic [15:0] win;
  logic        match;
  logic [2:0]  match_k;
  logic        hunt_expire;

  // Two-beat window: prev holds the earlier beat in the low half.
  assign win = {lane_if.raw_byte, prev_q};

  // Scan from the top so the lowest matching offset is the one that sticks.
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  assign hunt_expire = (hunt_cnt_q + 8'd1) == TIMEOUT_CNT;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; hs_en low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!lane_if.hs_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_HUNT;
        ST_HUNT: begin
          if (lane_if.raw_valid) begin
            if (match)            state_d = ST_ALIGNED;
            else if (hunt_expire) state_d = ST_ERROR;
          end
        end
        ST_ALIGNED: state_d = ST_ALIGNED;
        ST_ERROR:   state_d = ST_ERROR;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    prev_d       = prev_q;
    hunt_cnt_d   = hunt_cnt_q;
    bit_offset_d = bit_offset_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    sof_pend_d   = sof_pend_q;
    sync_err_d   = 1'b0;
    if (!lane_if.hs_en) begin
      // A beat arriving together with hs_en low is dropped.
      prev_d     = 8'd0;
      hunt_cnt_d = 8'd0;
      sof_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // HS-zero preamble is all zero, so a zero prefill lets the very
          // first beat be tested.
          prev_d     = 8'd0;
          hunt_cnt_d = 8'd0;
        end
        ST_HUNT: begin
          if (lane_if.raw_valid) begin
            prev_d = lane_if.raw_byte;
            if (match) begin
              bit_offset_d = match_k;
              sof_pend_d   = 1'b1;
            end else begin
              hunt_cnt_d = hunt_cnt_q + 8'd1;
              sync_err_d = hunt_expire;
            end
          end
        end
        ST_ALIGNED: begin
          // No relock here: a sync pattern in payload is just data.
          if (lane_if.raw_valid) begin
            prev_d       = lane_if.raw_byte;
            byte_out_d   = win[bit_offset_q +: 8];
            byte_valid_d = 1'b1;
            sof_d        = sof_pend_q;
            sof_pend_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= 8'd0;
      hunt_cnt_q   <= 8'd0;
      bit_offset_q <= 3'd0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      sof_pend_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      hunt_cnt_q   <= hunt_cnt_d;
      bit_offset_q <= bit_offset_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      sof_pend_q   <= sof_pend_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Outputs
  always_comb begin
    lane_if.byte_out   = byte_out_q;
    lane_if.byte_valid = byte_valid_q;
    lane_if.sof        = sof_q;
    lane_if.aligned    = (state_q == ST_ALIGNED);
    lane_if.bit_offset = bit_offset_q;
    lane_if.sync_err   = sync_err_q;
    lane_if.dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mipi_rx_byte_align.sv
module tb_mipi_rx_byte_align;

  localparam logic [7:0] SYNC   = 8'hB8;
  localparam int         ST_IDLE = 0, ST_HUNT = 1, ST_ERROR = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mipi_rx_byte_align_if lane_if();

  mipi_rx_byte_align #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lane_if (lane_if)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {sof, byte}
  logic [8:0] exp_q[$];
  logic [7:0] pay_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lane_if.byte_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq("byte_out", 32'(lane_if.byte_out), 32'(e[7:0]));
        check_eq("sof",      32'(lane_if.sof),      32'(e[8]));
      end
    end
  end

  // Driver: called at a negedge, returns at the next negedge
  task automatic beat(input logic v, input logic [7:0] b);
    lane_if.raw_valid = v;
    lane_if.raw_byte  = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One burst: 16 zero preamble bits, sync at bit 16+off, then pay_q.
  // Sync completes in beat 3, so payload byte i emerges from beat 4+i.
  // cut >= 0 drives only that many payload beats.
  task automatic burst(input int off, input bit gap, input int cut);
    logic [255:0] stream;
    int s, nbeats;
    stream = '0;
    s = 16 + off;
    stream[s +: 8] = SYNC;
    for (int i = 0; i < pay_q.size(); i++) stream[s + 8 + 8*i +: 8] = pay_q[i];
    nbeats = (cut >= 0) ? 4 + cut : 4 + pay_q.size();
    lane_if.hs_en = 1'b1;
    beat(1'b0, 8'h00);
    for (int b = 0; b < nbeats; b++) begin
      if (b >= 4) exp_q.push_back({(b == 4), pay_q[b-4]});
      beat(1'b1, stream[8*b +: 8]);
      check_eq("aligned", 32'(lane_if.aligned), 32'(b >= 3));
      if (b >= 3) check_eq("bit_offset", 32'(lane_if.bit_offset), 32'(off));
      if (gap) begin
        beat(1'b0, 8'($urandom_range(0, 255)));
        check_eq("gap_no_byte", 32'(lane_if.byte_valid), 32'd0);
      end
    end
  endtask

  // Drop hs_en, optionally with a simultaneous raw beat that must be dropped
  task automatic end_burst(input int off, input bit with_beat);
    lane_if.hs_en = 1'b0;
    beat(with_beat, 8'hC3);
    check_eq("drop_aligned",    32'(lane_if.aligned),    32'd0);
    check_eq("drop_byte_valid", 32'(lane_if.byte_valid), 32'd0);
    check_eq("drop_state",      32'(lane_if.dbg_state),  32'(ST_IDLE));
    check_eq("bit_offset_hold", 32'(lane_if.bit_offset), 32'(off));
    check_eq("sb_drained",      32'(exp_q.size()),       32'd0);
  endtask

  // 16 valid zero beats must time out with a single sync_err pulse
  task automatic hunt_timeout(input bit gap);
    lane_if.hs_en = 1'b1;
    beat(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 8'h00);
      check_eq("sync_err", 32'(lane_if.sync_err), 32'(i == 15));
      if (gap) begin
        beat(1'b0, 8'($urandom_range(0, 255)));
        check_eq("sync_err_gap", 32'(lane_if.sync_err), 32'd0);
      end
    end
    // Sync arriving in ERROR must not lock
    beat(1'b1, SYNC);
    beat(1'b1, SYNC);
    check_eq("err_state",    32'(lane_if.dbg_state), 32'(ST_ERROR));
    check_eq("err_aligned",  32'(lane_if.aligned),   32'd0);
    check_eq("err_pulse_1x", 32'(lane_if.sync_err),  32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_byte_out"},   32'(lane_if.byte_out),   32'd0);
    check_eq({tag, "_byte_valid"}, 32'(lane_if.byte_valid), 32'd0);
    check_eq({tag, "_sof"},        32'(lane_if.sof),        32'd0);
    check_eq({tag, "_aligned"},    32'(lane_if.aligned),    32'd0);
    check_eq({tag, "_bit_offset"}, 32'(lane_if.bit_offset), 32'd0);
    check_eq({tag, "_sync_err"},   32'(lane_if.sync_err),   32'd0);
    check_eq({tag, "_state"},      32'(lane_if.dbg_state),  32'(ST_IDLE));
  endtask

  initial begin
    int roff;
    rst_n             = 1'b0;
    lane_if.hs_en     = 1'b0;
    lane_if.raw_valid = 1'b0;
    lane_if.raw_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // T1: offset 0
    pay_q = '{8'h11, 8'h22};
    burst(0, 1'b0, -1);
    end_burst(0, 1'b0);

    // T2: offset 3
    pay_q = '{8'hA5, 8'h3C};
    burst(3, 1'b0, -1);
    end_burst(3, 1'b0);

    // T3: timeout, then a normal lock
    hunt_timeout(1'b0);
    end_burst(3, 1'b0);
    pay_q = '{8'h11, 8'h22};
    burst(0, 1'b0, -1);
    end_burst(0, 1'b0);

    // T4: burst ends mid-payload with a beat in flight, then offset 5
    pay_q = '{8'h5E, 8'hB8, 8'h77, 8'h01};
    burst(2, 1'b0, 2);
    end_burst(2, 1'b1);
    pay_q = '{8'hDE, 8'hAD, 8'hB8, 8'hEF};
    burst(5, 1'b0, -1);
    end_burst(5, 1'b0);

    // T5: gaps on the T2 stream and on the timeout
    pay_q = '{8'hA5, 8'h3C};
    burst(3, 1'b1, -1);
    end_burst(3, 1'b0);
    hunt_timeout(1'b1);
    end_burst(3, 1'b0);

    // Random offset and payload
    roff = $urandom_range(0, 7);
    pay_q.delete();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    burst(roff, 1'b0, -1);
    end_burst(roff, 1'b0);

    // T6: async reset mid-ALIGNED, then relock
    pay_q = '{8'h66, 8'h77, 8'h88, 8'h99};
    burst(1, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    check_eq("sb_reset_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("restart_hunt", 32'(lane_if.dbg_state), 32'(ST_HUNT));
    pay_q = '{8'h12, 8'h34, 8'h56};
    burst(6, 1'b0, -1);
    end_burst(6, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
